// File: rtl/coin_collector_pkg.sv
// Shared definitions for the coin collector: state codes, coin encodings,
// product code range and credit width.
package coin_collector_pkg;

  localparam int CREDIT_W = 4;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_COMPARE = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_4    = 2'b11;

  localparam logic [2:0] PROD_MIN = 3'd1;
  localparam logic [2:0] PROD_MAX = 3'd6;

  function automatic logic [2:0] coinUnits(input logic [1:0] code);
    logic [2:0] units;
    case (code)
      COIN_1:  units = 3'd1;
      COIN_2:  units = 3'd2;
      COIN_4:  units = 3'd4;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

  function automatic logic isLegalProduct(input logic [2:0] code);
    return (code >= PROD_MIN) && (code <= PROD_MAX);
  endfunction

endpackage

// File: rtl/coin_collector_timeout.sv
// Idle-cycle timer for the COLLECT phase: counts run cycles since the last
// clear and pulses expired on the LIMIT-th consecutive run cycle.
module timeout_counter #(
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  // expired is combinational so the owner can leave COLLECT on this very edge
  assign expired = run && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (run && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/coin_collector.sv
// Vending coin collector: latches a product, accumulates coin credit and
// hands both to the comparator with a single compare_en pulse.
//
//   state      | meaning
//   IDLE       | waiting for a legal product selection
//   COLLECT    | accepting coins until confirm, cancel or timeout
//   COMPARE    | compare_en high, credit and product presented
//   HOLD       | outputs held one more cycle, then cleared
module coin_collector
  import coin_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel_valid,
  input  logic [2:0]          sel_code,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                confirm,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] valor_moedas,
  output logic [2:0]          valor_produto,
  output logic                compare_en,
  output logic                overflow,
  output logic                busy
);

  state_t state;
  state_t stateNext;

  logic              coinAccept;
  logic              inCollect;
  logic              timeoutExpired;
  logic [CREDIT_W:0] creditSum;

  assign inCollect  = (state == ST_COLLECT);
  assign coinAccept = coin_valid && (coin_value != COIN_NONE);
  assign creditSum  = {1'b0, valor_moedas} + {2'b00, coinUnits(coin_value)};

  timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) timeoutTimer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!inCollect || coinAccept),
    .run    (inCollect && !coinAccept && !confirm && !cancel),
    .expired(timeoutExpired)
  );

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (sel_valid && isLegalProduct(sel_code)) stateNext = ST_COLLECT;
      ST_COLLECT: if (cancel || confirm || timeoutExpired) stateNext = ST_COMPARE;
      ST_COMPARE: stateNext = ST_HOLD;
      ST_HOLD:    stateNext = ST_IDLE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      valor_moedas  <= '0;
      valor_produto <= 3'd0;
      compare_en    <= 1'b0;
      overflow      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state      <= stateNext;
      busy       <= (stateNext != ST_IDLE);
      // COMPARE is only ever entered from COLLECT, so this is a one-cycle pulse
      compare_en <= (stateNext == ST_COMPARE);
      case (state)
        ST_IDLE: begin
          if (sel_valid && isLegalProduct(sel_code)) begin
            valor_produto <= sel_code;
            valor_moedas  <= '0;
            overflow      <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (coinAccept) begin
            if (creditSum > {1'b0, CREDIT_MAX}) begin
              valor_moedas <= CREDIT_MAX;
              overflow     <= 1'b1;
            end else begin
              valor_moedas <= creditSum[CREDIT_W-1:0];
            end
          end
          // a zero product makes the comparator take its refund branch
          if (cancel) valor_produto <= 3'd0;
        end
        ST_HOLD: begin
          valor_moedas  <= '0;
          valor_produto <= 3'd0;
          overflow      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: directed scenarios plus random
// transactions checked against a transaction-level credit/product model.
module tb_coin_collector;

  localparam int TO = 20;

  logic       clk;
  logic       reset;
  logic       sel_valid;
  logic [2:0] sel_code;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       confirm;
  logic       cancel;
  logic [3:0] valor_moedas;
  logic [2:0] valor_produto;
  logic       compare_en;
  logic       overflow;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int coinQ[$];
  int gapMax = 0;
  logic prevCe = 1'b0;

  coin_collector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .sel_valid    (sel_valid),
    .sel_code     (sel_code),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .confirm      (confirm),
    .cancel       (cancel),
    .valor_moedas (valor_moedas),
    .valor_produto(valor_produto),
    .compare_en   (compare_en),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // compare_en must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (compare_en === 1'b1) begin
      compared++;
      assert (prevCe !== 1'b1) else begin
        mismatched++;
        $error("FAIL ce_consecutive: observed 1 expected 0");
      end
    end
    prevCe = compare_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    sel_valid = 0; sel_code = 0; coin_valid = 0; coin_value = 0;
    confirm = 0; cancel = 0;
  endtask

  task automatic junkInputs();
    sel_valid  = 1'($urandom);
    sel_code   = 3'($urandom);
    coin_valid = 1'($urandom);
    coin_value = 2'($urandom);
    confirm    = 1'($urandom);
    cancel     = 1'($urandom);
  endtask

  function automatic int unitsOf(input int enc);
    return (enc == 1) ? 1 : (enc == 2) ? 2 : (enc == 3) ? 4 : 0;
  endfunction

  // mode 0 = confirm, 1 = cancel, 2 = timeout; coins taken from coinQ
  task automatic transaction(input logic [2:0] code, input int mode, input int endCoin);
    int sum = 0;
    int expCredit;
    logic [2:0] expProd;
    sel_valid = 1; sel_code = code;
    tick();
    idleInputs();
    check("sel_busy", 8'(busy), 8'd1);
    check("sel_prod", 8'(valor_produto), 8'(code));
    check("sel_credit", 8'(valor_moedas), 8'd0);
    while (coinQ.size() > 0) begin
      int enc = coinQ.pop_front();
      int gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      for (int g = 0; g < gaps; g++) begin
        sel_valid = 1'($urandom); sel_code = 3'($urandom);
        coin_valid = 1'($urandom); coin_value = 2'b00;
        tick();
        check("gap_ce", 8'(compare_en), 8'd0);
        check("gap_prod", 8'(valor_produto), 8'(code));
      end
      coin_valid = 1; coin_value = 2'(enc);
      tick();
      idleInputs();
      sum += unitsOf(enc);
      check("coin_credit", 8'(valor_moedas), 8'((sum > 15) ? 15 : sum));
      check("coin_ovf", 8'(overflow), 8'(sum > 15));
    end
    if (mode == 2) begin
      for (int i = 0; i < TO - 1; i++) begin
        tick();
        if (i == TO - 2) check("to_early_ce", 8'(compare_en), 8'd0);
      end
      tick();
    end else begin
      confirm = (mode == 0);
      cancel  = (mode == 1);
      if (endCoin != 0) begin
        coin_valid = 1; coin_value = 2'(endCoin);
        sum += unitsOf(endCoin);
      end
      tick();
      idleInputs();
    end
    expCredit = (sum > 15) ? 15 : sum;
    expProd   = (mode == 1) ? 3'd0 : code;
    check("cmp_ce", 8'(compare_en), 8'd1);
    check("cmp_credit", 8'(valor_moedas), 8'(expCredit));
    check("cmp_prod", 8'(valor_produto), 8'(expProd));
    check("cmp_ovf", 8'(overflow), 8'(sum > 15));
    check("cmp_busy", 8'(busy), 8'd1);
    junkInputs();
    tick();
    check("hold_ce", 8'(compare_en), 8'd0);
    check("hold_credit", 8'(valor_moedas), 8'(expCredit));
    check("hold_prod", 8'(valor_produto), 8'(expProd));
    check("hold_busy", 8'(busy), 8'd1);
    junkInputs();
    tick();
    idleInputs();
    check("idle_credit", 8'(valor_moedas), 8'd0);
    check("idle_prod", 8'(valor_produto), 8'd0);
    check("idle_ovf", 8'(overflow), 8'd0);
    check("idle_busy", 8'(busy), 8'd0);
    check("idle_ce", 8'(compare_en), 8'd0);
  endtask

  initial begin
    idleInputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check("rst_credit", 8'(valor_moedas), 8'd0);
    check("rst_prod", 8'(valor_produto), 8'd0);
    check("rst_ce", 8'(compare_en), 8'd0);
    check("rst_ovf", 8'(overflow), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);

    // illegal codes and coins in IDLE are ignored
    for (int i = 0; i < 6; i++) begin
      sel_valid = 1; sel_code = (i % 2 == 0) ? 3'd7 : 3'd0;
      coin_valid = 1; coin_value = 2'(1 + i % 3);
      tick();
      check("idle_ign_busy", 8'(busy), 8'd0);
      check("idle_ign_credit", 8'(valor_moedas), 8'd0);
    end
    idleInputs();
    tick();

    coinQ = '{3, 1};
    transaction(3'd3, 0, 0);
    coinQ = '{3, 3, 3, 3, 2};
    transaction(3'd6, 0, 0);
    coinQ = '{2};
    transaction(3'd2, 2, 0);
    coinQ = '{};
    transaction(3'd4, 1, 2);
    coinQ = '{};
    transaction(3'd1, 2, 0);
    coinQ = '{3, 3};
    transaction(3'd5, 0, 3);

    // reset mid-COLLECT with credit 7 while confirm and a coin are pending
    sel_valid = 1; sel_code = 3'd5;
    tick();
    idleInputs();
    foreach (coinQ[i]) coinQ.delete(i);
    for (int i = 0; i < 3; i++) begin
      coin_valid = 1; coin_value = 2'(3 - i);
      tick();
    end
    idleInputs();
    check("pre_rst_credit", 8'(valor_moedas), 8'd7);
    reset = 1; confirm = 1; coin_valid = 1; coin_value = 2'b11;
    tick();
    reset = 0;
    idleInputs();
    check("mid_rst_credit", 8'(valor_moedas), 8'd0);
    check("mid_rst_prod", 8'(valor_produto), 8'd0);
    check("mid_rst_ce", 8'(compare_en), 8'd0);
    check("mid_rst_busy", 8'(busy), 8'd0);
    tick();
    check("post_rst_ce", 8'(compare_en), 8'd0);
    check("post_rst_busy", 8'(busy), 8'd0);

    // reset during COMPARE
    sel_valid = 1; sel_code = 3'd2;
    tick();
    sel_valid = 0; coin_valid = 1; coin_value = 2'b10; confirm = 1;
    tick();
    idleInputs();
    check("cmp2_ce", 8'(compare_en), 8'd1);
    reset = 1;
    tick();
    reset = 0;
    check("cmp_rst_ce", 8'(compare_en), 8'd0);
    check("cmp_rst_credit", 8'(valor_moedas), 8'd0);
    check("cmp_rst_busy", 8'(busy), 8'd0);

    // random transactions
    gapMax = 2;
    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(0, 6);
      int mode = $urandom_range(0, 2);
      int endCoin = (mode == 2) ? 0 : int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) coinQ.push_back(int'($urandom_range(1, 3)));
      transaction(3'($urandom_range(1, 6)), mode, endCoin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
